// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the two-master memory arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_arb_timer.sv
// Saturating per-transaction wait counter; expired marks the abort threshold.
module mem_arb_timer #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [15:0] LAST = 16'(LIMIT - 32'd1);

  logic [15:0] r_count;

  // Count held at LAST once reached so expired stays asserted
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count <= 16'd0;
    end else if (i_clear) begin
      r_count <= 16'd0;
    end else if (i_enable && (r_count != LAST)) begin
      r_count <= r_count + 16'd1;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_expired = (r_count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory port between two masters,
// with a per-transaction timeout that aborts and returns ERR_RDATA.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_m0_valid,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  input  logic [STRB_W-1:0] i_m0_wstrb,
  output logic              o_m0_ready,
  output logic [DATA_W-1:0] o_m0_rdata,
  input  logic              i_m1_valid,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  input  logic [STRB_W-1:0] i_m1_wstrb,
  output logic              o_m1_ready,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic              o_s_valid,
  output logic [ADDR_W-1:0] o_s_addr,
  output logic [DATA_W-1:0] o_s_wdata,
  output logic [STRB_W-1:0] o_s_wstrb,
  input  logic              i_s_ready,
  input  logic [DATA_W-1:0] i_s_rdata,
  output logic              o_owner,
  output logic              o_busy,
  output logic              o_timeout
);

  arb_state_e        r_state, w_state_nxt;
  logic              r_owner, w_owner_nxt;
  logic              r_last_grant, w_last_nxt;
  logic              w_clear, w_enable, w_expired;
  logic              w_own_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_rdata;

  mem_arb_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_clear),
    .i_enable (w_enable),
    .o_expired(w_expired)
  );

  assign w_own_valid = r_owner ? i_m1_valid : i_m0_valid;

  // State, owner and round-robin pointer; last_grant=1 lets m0 win the first tie
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_nxt;
    end
  end

  // Next state and combinational routing; everything held low while in reset
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last_grant;
    w_clear     = 1'b1;
    w_enable    = 1'b0;
    w_ready     = 1'b0;
    w_rdata     = {DATA_W{1'b0}};
    o_s_valid   = 1'b0;
    o_s_addr    = {ADDR_W{1'b0}};
    o_s_wdata   = {DATA_W{1'b0}};
    o_s_wstrb   = {STRB_W{1'b0}};
    o_owner     = 1'b0;
    o_busy      = 1'b0;
    o_timeout   = 1'b0;
    if (!reset) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_m0_valid || i_m1_valid) begin
            w_state_nxt = ST_BUSY;
            w_owner_nxt = (i_m0_valid && i_m1_valid) ? ~r_last_grant : i_m1_valid;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_BUSY: begin
          w_clear   = 1'b0;
          w_enable  = 1'b1;
          o_busy    = 1'b1;
          o_owner   = r_owner;
          o_s_addr  = r_owner ? i_m1_addr  : i_m0_addr;
          o_s_wdata = r_owner ? i_m1_wdata : i_m0_wdata;
          o_s_wstrb = r_owner ? i_m1_wstrb : i_m0_wstrb;
          // Completion beats timeout; a dropped request is abandoned silently
          if (!w_own_valid) begin
            w_state_nxt = ST_IDLE;
          end else if (i_s_ready) begin
            o_s_valid   = 1'b1;
            w_ready     = 1'b1;
            w_rdata     = i_s_rdata;
            w_last_nxt  = r_owner;
            w_state_nxt = ST_IDLE;
          end else if (w_expired) begin
            w_ready     = 1'b1;
            w_rdata     = ERR_RDATA;
            o_timeout   = 1'b1;
            w_last_nxt  = r_owner;
            w_state_nxt = ST_IDLE;
          end else begin
            o_s_valid   = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign o_m0_ready = w_ready & ~r_owner;
  assign o_m1_ready = w_ready &  r_owner;
  assign o_m0_rdata = r_owner ? {DATA_W{1'b0}} : w_rdata;
  assign o_m1_rdata = r_owner ? w_rdata : {DATA_W{1'b0}};

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, max slave wait cycles per transaction before abort (range 2..65535).
REQ-002 Parameter ERR_RDATA, default 32'hDEAD_BEEF, rdata returned to a master on timeout.
REQ-003 clock  in  1  system clock; all state updates on rising edge.
REQ-004 reset  in  1  reset, synchronous, active-low.
REQ-005 mN_valid  in  1  master N (N=0,1) request; held high until mN_ready.
REQ-006 mN_addr / mN_wdata  in  32 each  master N address / write data.
REQ-007 mN_wstrb  in  4  master N byte strobes; 0 = read.
REQ-008 mN_ready  out  1  master N transaction complete, one-cycle pulse.
REQ-009 mN_rdata  out  32  master N read data, valid only with mN_ready.
REQ-010 s_valid  out  1  request to shared memory.
REQ-011 s_addr / s_wdata  out  32 each; s_wstrb  out  4  forwarded from owner.
REQ-012 s_ready  in  1  memory completion; s_rdata  in  32  memory read data.
REQ-013 owner  out  1  index of master currently granted (valid while busy=1).
REQ-014 busy  out  1  arbiter in BUSY state.
REQ-015 timeout  out  1  one-cycle pulse when a transaction is aborted.

Function
REQ-016 States IDLE and BUSY; owner register and last_grant register.
REQ-017 IDLE, no mN_valid -> stay IDLE; all outputs low.
REQ-018 IDLE, exactly one mN_valid -> BUSY next cycle, owner=N.
REQ-019 IDLE, both valid -> grant master != last_grant (round-robin).
REQ-020 Grant latency: s_valid rises the cycle after the request is first seen in IDLE.
REQ-021 BUSY: s_valid = m[owner]_valid; s_addr/s_wdata/s_wstrb combinationally from owner; all s_* low when not BUSY.
REQ-022 BUSY: m[owner]_ready = s_ready, m[owner]_rdata = s_rdata combinationally; non-owner ready=0, rdata=0.
REQ-023 On s_ready in BUSY: last_grant<=owner, state->IDLE; new grant earliest next cycle (one IDLE bubble between transactions).
REQ-024 Wait counter clears on BUSY entry, increments each BUSY cycle without s_ready, saturates.
REQ-025 Counter reaching TIMEOUT_CYCLES-1 without s_ready: s_valid forced low that cycle, m[owner]_ready=1 with rdata=ERR_RDATA, timeout=1, last_grant<=owner, ->IDLE.
REQ-026 s_ready in the same cycle as timeout threshold: s_ready wins, no timeout pulse.
REQ-027 Owner drops valid while BUSY (protocol violation): s_valid low, ->IDLE, last_grant unchanged, no ready pulse.
REQ-028 s_ready while IDLE or with s_valid low is ignored.
REQ-029 Non-owner request while BUSY waits; never lost, never starved (served next arbitration).

Reset
REQ-030 reset=0 at a clock edge: state IDLE, last_grant=1 (m0 wins first tie), owner=0, counter=0.
REQ-031 All outputs 0 during and immediately after reset, including mid-transaction; in-flight transaction dropped without ready.

Structure
REQ-032 Shared package holds state enum (IDLE, BUSY), ADDR_W=32, DATA_W=32, STRB_W=4.
REQ-033 One sub-module mem_arb_timer: saturating wait counter with clear/enable inputs and expired output.
REQ-034 No other sub-modules; masters/slave are Picorv32 native valid/ready ports.

Verification
REQ-035 m0 read 0x100 only, memory ready after 3 cycles with 0x12345678 -> s_valid 1 cycle after m0_valid, m0_ready one pulse, m0_rdata=0x12345678.
REQ-036 Both valid at reset exit -> m0 served first, then m1 after one IDLE cycle; repeat both held -> strict alternation 0,1,0,1.
REQ-037 m1 write 0x200 wstrb=4'b0011 wdata=0xAABBCCDD while m0 BUSY -> m1 forwarded unchanged after m0 ready; m0_ready never asserted for m1.
REQ-038 TIMEOUT_CYCLES=8, s_ready held low -> timeout and m0_ready pulse at 8th BUSY cycle, m0_rdata=0xDEADBEEF, arbiter IDLE next.
REQ-039 reset=0 during BUSY with s_ready pending -> no ready pulse, next tie goes to m0.
REQ-040 s_ready coincident with timeout threshold -> memory data returned, timeout stays 0.
